// File: rtl/ccip_mmio_csr_responder_if.sv
// CCI-P MMIO channel bundle between the CCI-P port and the AFU CSR responder.
// Header types use the CCI-P names so the bench and the RTL share one layout.
//
// Signals:
//   C0RxMmioWrValid  MMIO write request valid (port -> AFU)
//   C0RxMmioRdValid  MMIO read request valid (port -> AFU)
//   C0RxMmioHdr      request header: DW index, length code, transaction id
//   C0RxData         write payload, only [63:0] carries MMIO data
//   C2TxHdr          read response header (tid echoes the request)
//   C2TxMmioRdValid  read response valid, one cycle per response
//   C2TxData         read response data
// Modports: master = CCI-P port side, slave = AFU responder side.

typedef struct packed {
  logic [15:0] index;
  logic [1:0]  len;
  logic        rsvd;
  logic [8:0]  tid;
} CfgHdr_t;

typedef struct packed {
  logic [8:0] tid;
} MMIOHdr_t;

interface ccip_mmio_csr_responder_if #(
  parameter int CCIP_DATA_WIDTH        = 512,
  parameter int CCIP_MMIO_RDDATA_WIDTH = 64
);
  logic                              C0RxMmioWrValid;
  logic                              C0RxMmioRdValid;
  CfgHdr_t                           C0RxMmioHdr;
  logic [CCIP_DATA_WIDTH-1:0]        C0RxData;
  MMIOHdr_t                          C2TxHdr;
  logic                              C2TxMmioRdValid;
  logic [CCIP_MMIO_RDDATA_WIDTH-1:0] C2TxData;

  modport master (
    output C0RxMmioWrValid, C0RxMmioRdValid, C0RxMmioHdr, C0RxData,
    input  C2TxHdr, C2TxMmioRdValid, C2TxData
  );

  modport slave (
    input  C0RxMmioWrValid, C0RxMmioRdValid, C0RxMmioHdr, C0RxData,
    output C2TxHdr, C2TxMmioRdValid, C2TxData
  );
endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// AFU-side CCI-P MMIO responder holding a bank of 64-bit CSRs.
// Writes land one edge after they are sampled; every read that is accepted
// produces exactly one C2 response two edges after it is sampled, illegal
// reads answering with zero data so software never times out.
//
// Ports:
//   clk           CCI-P clock, all logic on posedge
//   SoftReset     synchronous active-high reset
//   mmio          slave side of ccip_mmio_csr_responder_if (C0 Rx in, C2 Tx out)
//   csr_q         flattened CSR contents, CSR k at [64k+63:64k]
//   csr_wr_pulse  bit k pulses for one cycle when a write updates CSR k
//
// Optional feature macro: CCIP_MMIO_STATS_EN
//   defined   -> CSR 1 = {read responses, writes performed}, CSR 2 = error
//                count (saturating 16 bit); both read-only.
//   undefined -> CSR 1 and CSR 2 are plain scratch registers, no counters.

module ccip_mmio_csr_responder #(
  parameter logic [15:0] CSR_BASE  = 16'h0000,
  parameter int          NUM_CSR   = 16,
  parameter logic [63:0] DFH_VALUE = 64'h0
) (
  input  logic                   clk,
  input  logic                   SoftReset,
  ccip_mmio_csr_responder_if.slave mmio,
  output logic [NUM_CSR*64-1:0]  csr_q,
  output logic [NUM_CSR-1:0]     csr_wr_pulse
);

  localparam int          CW   = $clog2(NUM_CSR);
  localparam logic [16:0] SPAN = 17'(2 * NUM_CSR);

  CfgHdr_t       hdr;
  logic [63:0]   wr_payload;
  logic [15:0]   offset;
  logic          in_range, odd, full, access_ok, writable, wr_do, rd_take;
  logic [CW-1:0] csr_num;
  logic          unused_ok;

  assign hdr        = mmio.C0RxMmioHdr;
  assign wr_payload = mmio.C0RxData[63:0];
  assign unused_ok  = &{1'b0, hdr.rsvd, offset, mmio.C0RxData[$bits(mmio.C0RxData)-1:64]};

  // Request decode. CSR_BASE is even, so offset[0] selects the half and
  // offset[CW:1] the CSR. CSR 0 (and the counter CSRs) silently swallow writes.
  always_comb begin
    offset    = hdr.index - CSR_BASE;
    in_range  = (hdr.index >= CSR_BASE) && ({1'b0, offset} < SPAN);
    odd       = offset[0];
    full      = (hdr.len == 2'b01);
    csr_num   = offset[CW:1];
    access_ok = in_range && ((hdr.len == 2'b00) || (full && !odd));
    writable  = (csr_num != '0);
`ifdef CCIP_MMIO_STATS_EN
    if ((csr_num == CW'(1)) || (csr_num == CW'(2))) writable = 1'b0;
`endif
    wr_do   = mmio.C0RxMmioWrValid && access_ok && writable;
    // A simultaneous write wins; the read is dropped without a response.
    rd_take = mmio.C0RxMmioRdValid && !mmio.C0RxMmioWrValid;
  end

  // Stage 1: registered, decoded request.
  logic          s1_wr, s1_rd, s1_rd_ok, s1_rd_odd, s1_rd_full;
  logic [CW-1:0] s1_wr_csr, s1_rd_csr;
  logic [1:0]    s1_wr_mask;
  logic [63:0]   s1_wr_data;
  logic [8:0]    s1_rd_tid;

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      s1_wr      <= 1'b0;
      s1_wr_csr  <= '0;
      s1_wr_mask <= '0;
      s1_wr_data <= '0;
      s1_rd      <= 1'b0;
      s1_rd_ok   <= 1'b0;
      s1_rd_csr  <= '0;
      s1_rd_odd  <= 1'b0;
      s1_rd_full <= 1'b0;
      s1_rd_tid  <= '0;
    end else begin
      s1_wr      <= wr_do;
      s1_wr_csr  <= csr_num;
      s1_wr_mask <= full ? 2'b11 : (odd ? 2'b10 : 2'b01);
      // A 4B payload is replicated so either half can take it from its own lane.
      s1_wr_data <= {(full ? wr_payload[63:32] : wr_payload[31:0]), wr_payload[31:0]};
      s1_rd      <= rd_take;
      s1_rd_ok   <= access_ok;
      s1_rd_csr  <= csr_num;
      s1_rd_odd  <= odd;
      s1_rd_full <= full;
      s1_rd_tid  <= hdr.tid;
    end
  end

  // CSR storage and the visible view (read-only slots overlaid).
  logic [63:0] csr_reg [NUM_CSR];
  logic [63:0] csr_val [NUM_CSR];

`ifdef CCIP_MMIO_STATS_EN
  logic [31:0] rd_count, wr_count;
  logic [15:0] err_count;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
`endif

  always_comb begin
    for (int k = 0; k < NUM_CSR; k++) csr_val[k] = csr_reg[k];
    csr_val[0] = DFH_VALUE;
`ifdef CCIP_MMIO_STATS_EN
    csr_val[1] = {rd_count, wr_count};
    csr_val[2] = {48'h0, err_count};
`endif
  end

  always_comb begin
    for (int k = 0; k < NUM_CSR; k++) csr_q[64*k +: 64] = csr_val[k];
  end

  // Stage 2 data mux; illegal reads answer zero.
  logic [63:0] rd_sel, rd_data;

  always_comb begin
    rd_sel  = csr_val[s1_rd_csr];
    rd_data = '0;
    if (s1_rd_ok) begin
      if (s1_rd_full)     rd_data = rd_sel;
      else if (s1_rd_odd) rd_data = {32'h0, rd_sel[63:32]};
      else                rd_data = {32'h0, rd_sel[31:0]};
    end
  end

  // The CSR update and the stage-2 capture share an edge, so a read sampled
  // alongside a write sees the old value and the next read sees the new one.
  logic        s2_valid;
  logic [8:0]  s2_tid;
  logic [63:0] s2_data;

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      for (int k = 0; k < NUM_CSR; k++) csr_reg[k] <= '0;
      csr_wr_pulse <= '0;
      s2_valid     <= 1'b0;
      s2_tid       <= '0;
      s2_data      <= '0;
    end else begin
      for (int k = 0; k < NUM_CSR; k++) begin
        csr_wr_pulse[k] <= s1_wr && (s1_wr_csr == CW'(k));
        if (s1_wr && (s1_wr_csr == CW'(k))) begin
          if (s1_wr_mask[0]) csr_reg[k][31:0]  <= s1_wr_data[31:0];
          if (s1_wr_mask[1]) csr_reg[k][63:32] <= s1_wr_data[63:32];
        end
      end
      s2_valid <= s1_rd;
      s2_tid   <= s1_rd ? s1_rd_tid : '0;
      s2_data  <= s1_rd ? rd_data : '0;
    end
  end

  // C2 Tx output register; header and data stay zero between responses.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      mmio.C2TxMmioRdValid <= 1'b0;
      mmio.C2TxHdr.tid     <= '0;
      mmio.C2TxData        <= '0;
    end else begin
      mmio.C2TxMmioRdValid <= s2_valid;
      mmio.C2TxHdr.tid     <= s2_tid;
      mmio.C2TxData        <= s2_data;
    end
  end

`ifdef CCIP_MMIO_STATS_EN
  // Errors are counted when sampled; a protocol violation with an illegal
  // write counts twice (the collision and the bad write).
  always_comb begin
    err_inc = {1'b0, (mmio.C0RxMmioWrValid && !access_ok)}
            + {1'b0, (mmio.C0RxMmioWrValid && mmio.C0RxMmioRdValid)}
            + {1'b0, (rd_take && !access_ok)};
    err_sum = {1'b0, err_count} + {15'h0, err_inc};
  end

  // Reads count as their response issues, so CSR 1 excludes the read of itself.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      rd_count  <= rd_count + {31'h0, s2_valid};
      wr_count  <= wr_count + {31'h0, s1_wr};
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Directed self-checking bench for ccip_mmio_csr_responder.
// Inputs change and outputs are sampled on the falling clock edge.
// Honours CCIP_MMIO_STATS_EN for the counter and scratch-register checks.

module tb_ccip_mmio_csr_responder;

  localparam logic [15:0] BASE = 16'h0010;
  localparam int          NCSR = 16;
  localparam logic [63:0] DFH  = 64'h1000_0000_0000_00A5;

  logic                clk;
  logic                SoftReset;
  logic [NCSR*64-1:0]  csr_q;
  logic [NCSR-1:0]     csr_wr_pulse;
  int                  vectors;
  int                  miscompares;

  ccip_mmio_csr_responder_if bus ();

  ccip_mmio_csr_responder #(
    .CSR_BASE  (BASE),
    .NUM_CSR   (NCSR),
    .DFH_VALUE (DFH)
  ) dut (
    .clk          (clk),
    .SoftReset    (SoftReset),
    .mmio         (bus),
    .csr_q        (csr_q),
    .csr_wr_pulse (csr_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setIdle();
    bus.C0RxMmioWrValid = 1'b0;
    bus.C0RxMmioRdValid = 1'b0;
    bus.C0RxMmioHdr     = '0;
    bus.C0RxData        = '0;
  endtask

  // Present one request for one clock, then return to idle.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] index,
                               input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
    bus.C0RxMmioWrValid   = wr;
    bus.C0RxMmioRdValid   = rd;
    bus.C0RxMmioHdr.index = index;
    bus.C0RxMmioHdr.len   = len;
    bus.C0RxMmioHdr.rsvd  = 1'b0;
    bus.C0RxMmioHdr.tid   = tid;
    bus.C0RxData          = {448'h0, data};
    @(negedge clk);
    setIdle();
  endtask

  // Issue one read and check the full response window around its 2-cycle latency.
  task automatic readCheck(input string tag, input logic [15:0] index, input logic [1:0] len,
                           input logic [8:0] tid, input logic [63:0] expected);
    applyStimulus(1'b0, 1'b1, index, len, tid, 64'h0);
    checkOutput({tag, "/valid_c1"}, 64'(bus.C2TxMmioRdValid), 64'd0);
    @(negedge clk);
    checkOutput({tag, "/valid_c2"}, 64'(bus.C2TxMmioRdValid), 64'd0);
    @(negedge clk);
    checkOutput({tag, "/valid"}, 64'(bus.C2TxMmioRdValid), 64'd1);
    checkOutput({tag, "/tid"}, 64'(bus.C2TxHdr.tid), 64'(tid));
    checkOutput({tag, "/data"}, bus.C2TxData, expected);
    @(negedge clk);
    checkOutput({tag, "/valid_after"}, 64'(bus.C2TxMmioRdValid), 64'd0);
    checkOutput({tag, "/data_after"}, bus.C2TxData, 64'd0);
  endtask

  logic [15:0] b2b_idx [4];
  logic [63:0] b2b_exp [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    b2b_idx = '{BASE + 16'd6, BASE + 16'd7, BASE + 16'd8, BASE + 16'd9};
    b2b_exp = '{64'hCAFEF00D, 64'hDEADBEEF, 64'h0, 64'h12345678};
    setIdle();
    SoftReset = 1'b1;

    // A read presented during reset must be ignored.
    @(negedge clk);
    bus.C0RxMmioRdValid = 1'b1;
    bus.C0RxMmioHdr.tid = 9'h1FF;
    @(negedge clk);
    setIdle();
    @(negedge clk);
    checkOutput("rst_valid", 64'(bus.C2TxMmioRdValid), 64'd0);
    checkOutput("rst_hdr", 64'(bus.C2TxHdr), 64'd0);
    checkOutput("rst_data", bus.C2TxData, 64'd0);
    checkOutput("rst_pulse", 64'(csr_wr_pulse), 64'd0);
    checkOutput("rst_csr0_q", csr_q[63:0], DFH);
    checkOutput("rst_csr3_q", csr_q[3*64 +: 64], 64'd0);

    // First request shares the edge where reset is first low.
    SoftReset = 1'b0;
    readCheck("dfh_rd", BASE, 2'b01, 9'h005, DFH);

    // 8B write to CSR 3, pulse and half reads.
    applyStimulus(1'b1, 1'b0, BASE + 16'd6, 2'b01, 9'h0, 64'hDEADBEEF_CAFEF00D);
    checkOutput("wr3_pulse_early", 64'(csr_wr_pulse), 64'd0);
    @(negedge clk);
    checkOutput("wr3_pulse", 64'(csr_wr_pulse), 64'h8);
    checkOutput("wr3_csr_q", csr_q[3*64 +: 64], 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    checkOutput("wr3_pulse_end", 64'(csr_wr_pulse), 64'd0);
    readCheck("csr3_lo", BASE + 16'd6, 2'b00, 9'h006, 64'h0000_0000_CAFEF00D);
    readCheck("csr3_hi", BASE + 16'd7, 2'b00, 9'h007, 64'h0000_0000_DEADBEEF);

    // 4B write into the high half of CSR 4.
    applyStimulus(1'b1, 1'b0, BASE + 16'd9, 2'b00, 9'h0, 64'hFFFF_FFFF_1234_5678);
    readCheck("csr4_full", BASE + 16'd8, 2'b01, 9'h008, 64'h12345678_00000000);

    // Four back-to-back reads; responses arrive on consecutive cycles in order.
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        bus.C0RxMmioRdValid   = 1'b1;
        bus.C0RxMmioHdr.index = b2b_idx[i];
        bus.C0RxMmioHdr.len   = 2'b00;
        bus.C0RxMmioHdr.tid   = 9'(i + 1);
      end else begin
        setIdle();
      end
      @(negedge clk);
      if (i >= 2 && i <= 5) begin
        checkOutput($sformatf("b2b_valid_%0d", i), 64'(bus.C2TxMmioRdValid), 64'd1);
        checkOutput($sformatf("b2b_tid_%0d", i), 64'(bus.C2TxHdr.tid), 64'(i - 1));
        checkOutput($sformatf("b2b_data_%0d", i), bus.C2TxData, b2b_exp[i-2]);
      end else begin
        checkOutput($sformatf("b2b_idle_%0d", i), 64'(bus.C2TxMmioRdValid), 64'd0);
      end
    end
    setIdle();

    // Error cases: out-of-range read still answers, illegal writes are dropped.
    readCheck("oor_rd", BASE + 16'd32, 2'b01, 9'h033, 64'h0);
    applyStimulus(1'b1, 1'b0, BASE + 16'd10, 2'b10, 9'h0, 64'hBAD0_BAD0_BAD0_BAD0);
    applyStimulus(1'b1, 1'b0, BASE + 16'd11, 2'b01, 9'h0, 64'hBAD1_BAD1_BAD1_BAD1);
    @(negedge clk);
    checkOutput("bad_wr_csr5", csr_q[5*64 +: 64], 64'd0);
    checkOutput("bad_wr_pulse", 64'(csr_wr_pulse), 64'd0);

`ifdef CCIP_MMIO_STATS_EN
    // 9 responses and 2 performed writes so far; 3 errors.
    readCheck("stats_counts", BASE + 16'd2, 2'b01, 9'h0C1, {32'd9, 32'd2});
    readCheck("stats_errors", BASE + 16'd4, 2'b01, 9'h0C2, 64'd3);
`else
    applyStimulus(1'b1, 1'b0, BASE + 16'd2, 2'b00, 9'h0, 64'h0000_0000_A5A5_A5A5);
    readCheck("scratch_csr1", BASE + 16'd2, 2'b01, 9'h0C1, 64'h0000_0000_A5A5_A5A5);
`endif

    // CSR 0 ignores writes; indices below the base answer zero.
    applyStimulus(1'b1, 1'b0, BASE, 2'b01, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    readCheck("dfh_ro", BASE, 2'b01, 9'h0D0, DFH);
    readCheck("below_base", BASE - 16'd2, 2'b01, 9'h0D1, 64'h0);

    // A read directly after a write sees the new value.
    applyStimulus(1'b1, 1'b0, BASE + 16'd12, 2'b01, 9'h0, 64'h0123_4567_89AB_CDEF);
    readCheck("wr_then_rd", BASE + 16'd12, 2'b01, 9'h0AA, 64'h0123_4567_89AB_CDEF);

    // Write and read together: write performed, read gets no response.
    applyStimulus(1'b1, 1'b1, BASE + 16'd10, 2'b01, 9'h077, 64'h55);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("collide_noresp_%0d", i), 64'(bus.C2TxMmioRdValid), 64'd0);
      @(negedge clk);
    end
    checkOutput("collide_noresp_3", 64'(bus.C2TxMmioRdValid), 64'd0);
    readCheck("collide_wr", BASE + 16'd10, 2'b01, 9'h078, 64'h55);

    // Reset flushes in-flight reads and clears scratch CSRs.
    bus.C0RxMmioRdValid   = 1'b1;
    bus.C0RxMmioHdr.index = BASE + 16'd6;
    bus.C0RxMmioHdr.len   = 2'b01;
    bus.C0RxMmioHdr.tid   = 9'h011;
    @(negedge clk);
    bus.C0RxMmioHdr.tid = 9'h012;
    SoftReset = 1'b1;
    @(negedge clk);
    setIdle();
    checkOutput("flush_valid", 64'(bus.C2TxMmioRdValid), 64'd0);
    checkOutput("flush_hdr", 64'(bus.C2TxHdr), 64'd0);
    checkOutput("flush_data", bus.C2TxData, 64'd0);
    @(negedge clk);
    checkOutput("flush_valid_c3", 64'(bus.C2TxMmioRdValid), 64'd0);
    @(negedge clk);
    checkOutput("flush_valid_c4", 64'(bus.C2TxMmioRdValid), 64'd0);
    SoftReset = 1'b0;
    readCheck("post_rst_csr3", BASE + 16'd6, 2'b01, 9'h013, 64'h0);
    checkOutput("post_rst_csr4_q", csr_q[4*64 +: 64], 64'd0);
    checkOutput("post_rst_csr0_q", csr_q[63:0], DFH);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccip_mmio_csr_responder.md
# ccip_mmio_csr_responder

AFU-side responder for CCI-P MMIO traffic: it accepts software MMIO write and read requests from the C0 Rx channel and holds a bank of 64-bit CSRs. It returns MMIO read responses on the C2 Tx channel with the request's tid. The block sits directly behind the CCI-P port inside the AFU, so the transaction logger sees its C2TxMmioRdValid responses paired with C0RxMmioRdValid requests. It is the standard CSR front end for ASE sample AFUs.

## Interface

Parameters:
- CSR_BASE, 16'h0000: DW (4-byte) index of CSR 0; must be even.
- NUM_CSR, 16: number of 64-bit CSRs (range 4..256).
- DFH_VALUE, 64'h0: read-only contents of CSR 0.

Ports (clock and reset first):
- clk  in  1  CCI-P clock; all logic on posedge.
- SoftReset  in  1  synchronous, active-high reset.
- C0RxMmioWrValid  in  1  MMIO write request valid.
- C0RxMmioRdValid  in  1  MMIO read request valid.
- C0RxMmioHdr  in  CfgHdr_t  index[15:0] in DW units, len[1:0] (00=4B, 01=8B, 10=64B), tid[8:0].
- C0RxData  in  CCIP_DATA_WIDTH  write payload; only [63:0] is used.
- C2TxHdr  out  MMIOHdr_t  response header; tid equals the request tid.
- C2TxMmioRdValid  out  1  read response valid, one cycle per response.
- C2TxData  out  CCIP_MMIO_RDDATA_WIDTH (64)  read response data.
- csr_q  out  NUM_CSR*64  flattened CSR contents, CSR k at [64k+63:64k], for AFU datapath use.
- csr_wr_pulse  out  NUM_CSR  bit k pulses one cycle after any accepted write to CSR k.

## Operation

- Address map: CSR k occupies DW indices CSR_BASE+2k (low half) and CSR_BASE+2k+1 (high half). An index outside [CSR_BASE, CSR_BASE+2*NUM_CSR-1] is out of range.
- CSR 0 is read-only and returns DFH_VALUE. Writes to CSR 0 are dropped silently; they are not counted as errors.
- 4B write: even index writes C0RxData[31:0] to CSR[31:0]; odd index writes C0RxData[31:0] to CSR[63:32]; the other half is untouched.
- 8B write to an even index writes C0RxData[63:0]. An 8B write to an odd index is dropped and counts as an error.
- 64B writes and len=11 writes are dropped and count as errors. Out-of-range writes are dropped and count as errors.
- 4B read returns the addressed half in C2TxData[31:0] with [63:32]=0. 8B read to an even index returns the full CSR. An 8B read to an odd index returns 0 and counts as an error.
- Every read request produces exactly one response, including out-of-range reads, 64B reads and len=11 reads. Those return 0 and count as errors. Software must never time out.
- Pipeline: stage 1 registers the request and decodes the CSR number, half and legality; stage 2 muxes the data and drives C2Tx. Reads are fully pipelined, one accepted per cycle, with unlimited outstanding.
- A write and a read to the same CSR in the same cycle: the read returns the pre-write value. A read one cycle after the write returns the new value.
- If C0RxMmioWrValid and C0RxMmioRdValid are both high (protocol violation): the write is performed, the read is dropped with no response, and one error is counted.

## Timing

- Read request sampled at edge T: C2TxMmioRdValid is high for the cycle following edge T+2, i.e. a 2-cycle latency. C2TxHdr.tid and C2TxData are valid only while it is high and are 0 otherwise.
- Write sampled at edge T: the CSR is updated at edge T+1, and csr_q and csr_wr_pulse reflect it after edge T+1.
- Reset values: C2TxMmioRdValid=0, C2TxHdr=0, C2TxData=0, csr_wr_pulse=0, all writable CSRs=0, counters=0.
- Requests presented while SoftReset is high are ignored.
- Reads in the pipeline when SoftReset asserts are flushed and produce no response.
- The first request is accepted on the first edge with SoftReset low.

## Configuration

- CCIP_MMIO_STATS_EN defined:
  - CSR 1 is read-only: [63:32] counts read responses issued, [31:0] counts writes performed. Both wrap modulo 2^32.
  - CSR 2 is read-only: [15:0] is the error count, saturating at 16'hFFFF; [63:16]=0.
  - Writes to CSR 1 and CSR 2 are dropped silently.
  - A read counts when its response issues, so a read of CSR 1 returns the count before its own response.
- CCIP_MMIO_STATS_EN undefined:
  - CSR 1 and CSR 2 are ordinary read/write scratch registers.
  - No counter logic is instantiated.

## Test plan

- Reset, then 8B read of index CSR_BASE with tid 9'h05 -> C2TxMmioRdValid one cycle at T+2, tid 9'h05, data = DFH_VALUE.
- 8B write 64'hDEADBEEF_CAFEF00D to CSR 3, then 4B reads of indices +6 and +7 -> 32'hCAFEF00D and 32'hDEADBEEF; csr_wr_pulse[3] is a single pulse.
- 4B write 32'h12345678 to index CSR_BASE+9 over CSR 4 = 0 -> 8B read returns 64'h12345678_00000000.
- Back-to-back reads on 4 consecutive cycles, tids 1..4 -> 4 consecutive response cycles in order, tids 1..4.
- Out-of-range 8B read, 64B write, and odd-index 8B write -> the read returns 0 with a response; with CCIP_MMIO_STATS_EN, CSR 2 reads 3.
- Reads issued at T and T+1, then SoftReset high at T+1 -> no responses; outputs are 0 on the next cycle; scratch CSRs read back 0 afterwards.
